// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one simpleuart transmit register interface between NREQ byte-stream
//   requesters. Arbitration is round-robin, and a grant is locked to its holder
//   until the holder delivers a byte flagged as last. After every reset release
//   the UART divider is written once before any data is sent.
//
//   Optional build macro: ARB_LOCK_TIMEOUT_EN
//     When defined, a lock whose holder stops presenting bytes for LOCK_TIMEOUT
//     consecutive cycles is force-released and lock_timeout pulses for one cycle.
//     When undefined, lock_timeout is tied low and a lock is held indefinitely.
//
// Ports
//   clk, resetn     clock, asynchronous active-low reset
//   req_valid[i]    requester i presents a byte
//   req_data        byte of requester i at [8i+7:8i]
//   req_last[i]     presented byte ends requester i's packet
//   req_ready[i]    byte of requester i accepted when valid&ready
//   grant_valid     a requester holds the UART; grant_id names it
//   lock_timeout    one-cycle pulse on a forced lock release
//   uart_div_we/di  UART divider write port (written once after reset)
//   uart_dat_we/di  UART data write port
//   uart_dat_wait   UART data backpressure, forwarded to the holder

module uart_tx_arbiter #(
  parameter int          NREQ         = 4,
  parameter int          IDW          = 2,
  parameter logic [31:0] DIVIDER      = 32'd104,
  parameter int          LOCK_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              grant_valid,
  output logic [IDW-1:0]    grant_id,
  output logic              lock_timeout,
  output logic [3:0]        uart_div_we,
  output logic [31:0]       uart_div_di,
  output logic              uart_dat_we,
  output logic [31:0]       uart_dat_di,
  input  logic              uart_dat_wait
);

  typedef enum logic [1:0] {INIT, IDLE, SEND} state_t;

  state_t         state_reg, state_next;
  logic [IDW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [IDW-1:0] grant_id_reg, grant_id_next;
  logic           grant_valid_reg, grant_valid_next;
  logic [3:0]     div_we_reg, div_we_next;
  logic [31:0]    div_di_reg, div_di_next;

  // Per-requester byte view of the flat data bus.
  logic [7:0] req_byte [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_byte[gi]  = req_data[8*gi +: 8];
      assign req_ready[gi] = (state_reg == SEND) && (grant_id_reg == IDW'(gi)) && !uart_dat_wait;
    end
  endgenerate

  logic       in_send;
  logic       sel_valid;
  logic       sel_last;
  logic [7:0] sel_byte;
  logic       accept;

  assign in_send   = (state_reg == SEND);
  assign sel_valid = req_valid[grant_id_reg];
  assign sel_last  = req_last[grant_id_reg];
  assign sel_byte  = req_byte[grant_id_reg];
  assign accept    = in_send && sel_valid && !uart_dat_wait;

  assign uart_dat_we  = in_send && sel_valid;
  assign uart_dat_di  = in_send ? {24'h0, sel_byte} : 32'h0;
  assign uart_div_we  = div_we_reg;
  assign uart_div_di  = div_di_reg;
  assign grant_valid  = grant_valid_reg;
  assign grant_id     = grant_id_reg;

  // Rotating-priority search: first valid index at or above rr_ptr, wrapping.
  // One bit of headroom keeps rr_ptr+k from overflowing before the wrap.
  logic           found;
  logic [IDW-1:0] winner;
  logic [IDW:0]   cand_sum;
  logic [IDW-1:0] cand_idx;

  always_comb begin
    found    = 1'b0;
    winner   = '0;
    cand_sum = '0;
    cand_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_sum = {1'b0, rr_ptr_reg} + (IDW+1)'(k);
      if (cand_sum >= (IDW+1)'(NREQ))
        cand_sum = cand_sum - (IDW+1)'(NREQ);
      cand_idx = cand_sum[IDW-1:0];
      if (!found && req_valid[cand_idx]) begin
        found  = 1'b1;
        winner = cand_idx;
      end
    end
  end

  // Pointer value after releasing the current holder: (grant_id+1) mod NREQ.
  logic [IDW:0]   gid_inc;
  logic [IDW-1:0] ptr_after;
  assign gid_inc   = {1'b0, grant_id_reg} + (IDW+1)'(1);
  assign ptr_after = (gid_inc >= (IDW+1)'(NREQ)) ? '0 : gid_inc[IDW-1:0];

`ifdef ARB_LOCK_TIMEOUT_EN
  logic [15:0] idle_cnt_reg, idle_cnt_next;
  logic        lock_timeout_reg, lock_timeout_next;
  assign lock_timeout = lock_timeout_reg;
`else
  assign lock_timeout = 1'b0;
`endif

  always_comb begin
    state_next       = state_reg;
    rr_ptr_next      = rr_ptr_reg;
    grant_id_next    = grant_id_reg;
    grant_valid_next = grant_valid_reg;
    div_we_next      = 4'h0;
    div_di_next      = 32'h0;
`ifdef ARB_LOCK_TIMEOUT_EN
    idle_cnt_next     = idle_cnt_reg;
    lock_timeout_next = 1'b0;
`endif
    case (state_reg)
      INIT: begin
        div_we_next = 4'hF;
        div_di_next = DIVIDER;
        state_next  = IDLE;
      end
      IDLE: begin
        if (found) begin
          grant_id_next    = winner;
          grant_valid_next = 1'b1;
          state_next       = SEND;
`ifdef ARB_LOCK_TIMEOUT_EN
          idle_cnt_next = 16'h0;
`endif
        end
      end
      SEND: begin
        if (accept) begin
`ifdef ARB_LOCK_TIMEOUT_EN
          idle_cnt_next = 16'h0;
`endif
          if (sel_last) begin
            grant_valid_next = 1'b0;
            rr_ptr_next      = ptr_after;
            state_next       = IDLE;
          end
        end
`ifdef ARB_LOCK_TIMEOUT_EN
        else if (!sel_valid) begin
          // Holder has gone quiet; release once the count reaches its limit.
          if (idle_cnt_reg == 16'(LOCK_TIMEOUT - 1)) begin
            grant_valid_next  = 1'b0;
            rr_ptr_next       = ptr_after;
            state_next        = IDLE;
            lock_timeout_next = 1'b1;
          end else begin
            idle_cnt_next = idle_cnt_reg + 16'h1;
          end
        end
`endif
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg       <= INIT;
      rr_ptr_reg      <= '0;
      grant_id_reg    <= '0;
      grant_valid_reg <= 1'b0;
      div_we_reg      <= 4'h0;
      div_di_reg      <= 32'h0;
`ifdef ARB_LOCK_TIMEOUT_EN
      idle_cnt_reg     <= 16'h0;
      lock_timeout_reg <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      rr_ptr_reg      <= rr_ptr_next;
      grant_id_reg    <= grant_id_next;
      grant_valid_reg <= grant_valid_next;
      div_we_reg      <= div_we_next;
      div_di_reg      <= div_di_next;
`ifdef ARB_LOCK_TIMEOUT_EN
      idle_cnt_reg     <= idle_cnt_next;
      lock_timeout_reg <= lock_timeout_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int          NREQ         = 4;
  localparam int          IDW          = 2;
  localparam logic [31:0] DIVIDER      = 32'd104;
  localparam int          LOCK_TIMEOUT = 16;

  logic              clk;
  logic              resetn;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              grant_valid;
  logic [IDW-1:0]    grant_id;
  logic              lock_timeout;
  logic [3:0]        uart_div_we;
  logic [31:0]       uart_div_di;
  logic              uart_dat_we;
  logic [31:0]       uart_dat_di;
  logic              uart_dat_wait;

  uart_tx_arbiter #(
    .NREQ(NREQ), .IDW(IDW), .DIVIDER(DIVIDER), .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .grant_valid(grant_valid), .grant_id(grant_id), .lock_timeout(lock_timeout),
    .uart_div_we(uart_div_we), .uart_div_di(uart_div_di),
    .uart_dat_we(uart_dat_we), .uart_dat_di(uart_dat_di), .uart_dat_wait(uart_dat_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- requester queues, observed/expected streams ----------------
  typedef struct {logic [7:0] b; logic last;} byte_t;
  typedef struct {int id; logic [31:0] d;} obs_t;

  byte_t q  [NREQ][$];
  byte_t mq [NREQ][$];
  int    gap[NREQ];
  obs_t  seen[$];
  obs_t  expq[$];
  int    model_rr;

  task automatic add_byte(input int i, input logic [7:0] b, input logic last);
    q[i].push_back(byte_t'{b, last});
  endtask

  task automatic exp_push(input int id, input logic [7:0] b);
    expq.push_back(obs_t'{id, {24'h0, b}});
  endtask

  // Reference: whole packets granted round-robin among non-empty queues.
  task automatic model_expect();
    int    found;
    byte_t e;
    for (int i = 0; i < NREQ; i++) mq[i] = q[i];
    forever begin
      found = -1;
      for (int k = 0; k < NREQ; k++)
        if (found < 0 && mq[(model_rr + k) % NREQ].size() > 0) found = (model_rr + k) % NREQ;
      if (found < 0) break;
      do begin
        e = mq[found].pop_front();
        exp_push(found, e.b);
      end while (!e.last);
      model_rr = (found + 1) % NREQ;
    end
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check($sformatf("%s_count", tag), seen.size(), expq.size());
    n = (seen.size() < expq.size()) ? seen.size() : expq.size();
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s_id%0d", tag, k), seen[k].id, expq[k].id);
      check($sformatf("%s_dat%0d", tag, k), seen[k].d, expq[k].d);
    end
    seen.delete();
    expq.delete();
  endtask

  // Drives all queues until drained; called and returns at posedge+1.
  task automatic run_queues(input string tag, input bit rwait, input bit rgap);
    int              cyc, viol, left;
    logic [NREQ-1:0] acc, mask;
    logic            lb;
    cyc = 0; viol = 0; left = 0;
    for (int i = 0; i < NREQ; i++) begin left += q[i].size(); gap[i] = 0; end
    while (left > 0 && cyc < 3000) begin
      for (int i = 0; i < NREQ; i++) begin
        if (q[i].size() > 0 && gap[i] == 0) begin
          req_valid[i]        = 1'b1;
          req_data[8*i +: 8]  = q[i][0].b;
          req_last[i]         = q[i][0].last;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      uart_dat_wait = rwait ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(negedge clk);
      mask = grant_valid ? (NREQ'(1) << grant_id) : '0;
      if ((req_ready & ~mask) != '0) viol++;
      if (uart_dat_we && !uart_dat_wait) begin
        seen.push_back(obs_t'{int'(grant_id), uart_dat_di});
        $display("%s txn id=%0d data=%08h", tag, grant_id, uart_dat_di);
      end
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (gap[i] > 0) gap[i]--;
        if (acc[i]) begin
          lb = q[i][0].last;
          void'(q[i].pop_front());
          left--;
          if (rgap && !lb && $urandom_range(0, 2) == 0) gap[i] = $urandom_range(1, 3);
        end
      end
      cyc++;
    end
    req_valid = '0;
    uart_dat_wait = 1'b0;
    check($sformatf("%s_drained", tag), left, 0);
    check($sformatf("%s_ready_holder_only", tag), viol, 0);
    for (int i = 0; i < NREQ; i++) q[i].delete();
  endtask

  // Asserts reset mid-cycle, checks reset values, releases it and checks the
  // one-shot divider write. Called and returns at posedge+1 with the DUT idle.
  task automatic do_reset(input string tag);
    int          fcnt, other, we_seen;
    logic [31:0] di_at;
    #2 resetn = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; uart_dat_wait = 1'b0;
    @(negedge clk);
    check({tag, "_gv"},    grant_valid,  0);
    check({tag, "_gid"},   grant_id,     0);
    check({tag, "_lto"},   lock_timeout, 0);
    check({tag, "_divwe"}, uart_div_we,  0);
    check({tag, "_divdi"}, uart_div_di,  0);
    check({tag, "_datwe"}, uart_dat_we,  0);
    check({tag, "_datdi"}, uart_dat_di,  0);
    check({tag, "_rdy"},   req_ready,    0);
    @(posedge clk); @(posedge clk); #1 resetn = 1'b1;
    fcnt = 0; other = 0; we_seen = 0; di_at = 32'h0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (uart_div_we == 4'hF) begin fcnt++; di_at = uart_div_di; end
      else if (uart_div_we != 4'h0 || uart_div_di != 32'h0) other++;
      if (uart_dat_we) we_seen++;
      @(posedge clk); #1;
    end
    check({tag, "_div_pulse_cycles"}, fcnt, 1);
    check({tag, "_div_value"}, di_at, DIVIDER);
    check({tag, "_div_idle_nonzero"}, other, 0);
    check({tag, "_dat_we_in_init"}, we_seen, 0);
    $display("%s reset/divider sequence applied", tag);
  endtask

  // ---------------- single-cycle vector table ----------------
  typedef struct {
    logic [3:0] valid; logic [7:0] d0; logic [3:0] last; logic wt;
    logic e_we; logic [7:0] e_byte; logic [3:0] e_rdy; logic e_gv; logic [1:0] e_gid;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int          first, pulses;
    bit          held_ok;
    logic [31:0] lt_seen;

    resetn = 1'b1; req_valid = '0; req_data = '0; req_last = '0; uart_dat_wait = 1'b0;
    @(posedge clk); #1;
    do_reset("rst0");

    // idle -> grant 0 -> accept single byte; then a 5-cycle stall before accept
    tbl[0]  = '{4'b0001, 8'h55, 4'b0001, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
    tbl[1]  = '{4'b0001, 8'h55, 4'b0001, 1'b0, 1'b1, 8'h55, 4'b0001, 1'b1, 2'd0};
    tbl[2]  = '{4'b0000, 8'h00, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
    tbl[3]  = '{4'b0001, 8'hA3, 4'b0001, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
    for (int k = 4; k <= 8; k++)
      tbl[k] = '{4'b0001, 8'hA3, 4'b0001, 1'b1, 1'b1, 8'hA3, 4'b0000, 1'b1, 2'd0};
    tbl[9]  = '{4'b0001, 8'hA3, 4'b0001, 1'b0, 1'b1, 8'hA3, 4'b0001, 1'b1, 2'd0};
    tbl[10] = '{4'b0000, 8'h00, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};

    for (int v = 0; v < 11; v++) begin
      req_valid = tbl[v].valid;
      req_data  = {24'h0, tbl[v].d0};
      req_last  = tbl[v].last;
      uart_dat_wait = tbl[v].wt;
      @(negedge clk);
      check($sformatf("vec%0d_dat_we", v), uart_dat_we, tbl[v].e_we);
      check($sformatf("vec%0d_ready", v), req_ready, tbl[v].e_rdy);
      check($sformatf("vec%0d_grant_valid", v), grant_valid, tbl[v].e_gv);
      if (tbl[v].e_we) check($sformatf("vec%0d_dat_di", v), uart_dat_di, {24'h0, tbl[v].e_byte});
      if (tbl[v].e_gv) check($sformatf("vec%0d_grant_id", v), grant_id, tbl[v].e_gid);
      $display("vec%0d valid=%b wait=%b -> we=%b di=%08h rdy=%b gv=%b gid=%0d",
               v, req_valid, uart_dat_wait, uart_dat_we, uart_dat_di, req_ready, grant_valid, grant_id);
      @(posedge clk); #1;
    end

    // Reset in the middle of a locked packet: the partial packet is abandoned.
    req_valid = 4'b0010; req_data = {16'h0, 8'h9A, 8'h00}; req_last = 4'b0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_reset("rst_mid");

    // Round robin with req0 and req2 always holding single-byte packets.
    add_byte(0, 8'hA0, 1'b1); add_byte(0, 8'hA1, 1'b1);
    add_byte(2, 8'hC0, 1'b1); add_byte(2, 8'hC1, 1'b1);
    exp_push(0, 8'hA0); exp_push(2, 8'hC0); exp_push(0, 8'hA1); exp_push(2, 8'hC1);
    run_queues("rr", 1'b0, 1'b0);
    compare_stream("rr");

    // Packet lock: req1's 3-byte packet is contiguous although req0 waits.
    do_reset("rst_lock");
    add_byte(0, 8'h10, 1'b1); add_byte(0, 8'h11, 1'b1);
    add_byte(1, 8'h21, 1'b0); add_byte(1, 8'h22, 1'b0); add_byte(1, 8'h23, 1'b1);
    exp_push(0, 8'h10); exp_push(1, 8'h21); exp_push(1, 8'h22); exp_push(1, 8'h23); exp_push(0, 8'h11);
    run_queues("lock", 1'b1, 1'b0);
    compare_stream("lock");

    // Randomized packet mixes with random backpressure and mid-packet gaps.
    do_reset("rst_rand");
    model_rr = 0;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        int npk = $urandom_range(0, 3);
        for (int p = 0; p < npk; p++) begin
          int len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) add_byte(i, 8'($urandom_range(0, 255)), b == len - 1);
        end
      end
      model_expect();
      run_queues($sformatf("rand%0d", r), 1'b1, 1'b1);
      compare_stream($sformatf("rand%0d", r));
    end

    // Lock held by a requester that goes quiet after one non-last byte.
    do_reset("rst_to");
    req_valid = 4'b0010; req_data = {16'h0, 8'h77, 8'h11}; req_last = 4'b0001;
    @(posedge clk); #1;
    req_valid = 4'b0011;
    @(negedge clk);
    check("to_first_gid", grant_id, 1);
    check("to_first_we", uart_dat_we, 1);
    check("to_first_di", uart_dat_di, 32'h77);
    @(posedge clk); #1;
    req_valid = 4'b0001;
    first = 0; pulses = 0; held_ok = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      lt_seen = {31'h0, lock_timeout};
      if (lt_seen[0]) begin pulses++; if (first == 0) first = n; end
      if (!(grant_valid && grant_id == 2'd1 && !uart_dat_we)) held_ok = 1'b0;
`ifdef ARB_LOCK_TIMEOUT_EN
      if (first != 0 && n == first + 1) begin
        check("to_after_gv", grant_valid, 1);
        check("to_after_gid", grant_id, 0);
        check("to_after_di", uart_dat_di, 32'h11);
      end
`endif
      @(posedge clk); #1;
    end
    $display("timeout seq: first_pulse=%0d pulses=%0d held=%0d", first, pulses, held_ok);
`ifdef ARB_LOCK_TIMEOUT_EN
    check("to_pulse_cycle", first, LOCK_TIMEOUT + 1);
    check("to_pulse_count", pulses, 1);
`else
    check("to_pulse_count", pulses, 0);
    check("to_lock_held", {31'h0, held_ok}, 1);
`endif
    req_valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
